fifo_rd_unpack: RTL and testbench

//   Read-side consumer of the 128-bit dual-clock FIFO, in the rclk domain.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_rd_unpack.sv | 93 +++++++++
 tb/tb_fifo_rd_unpack.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the dual-clock FIFO and its read-side consumers.
package fifo_pkg;
  localparam int FIFO_DSIZE     = 128;
  localparam int FIFO_ASIZE     = 9;
  localparam int FIFO_OSIZE     = 16;
  localparam int FIFO_FRAME_LEN = 784;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_STREAM = 1'b1
  } rd_state_t;
endpackage

// File: rtl/fifo_rd_unpack.sv
// Pops DSIZE-bit FIFO words and serialises them, LSB lane first, into OSIZE-bit
// valid/ready elements, tagging the last element of every FRAME_LEN-element frame.
module fifo_rd_unpack
  import fifo_pkg::*;
#(
  parameter int DSIZE     = FIFO_DSIZE,
  parameter int OSIZE     = FIFO_OSIZE,
  parameter int FRAME_LEN = FIFO_FRAME_LEN
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  output logic [OSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             frame_done
);

  localparam int LANES  = DSIZE / OSIZE;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int ELEM_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  if (DSIZE % OSIZE != 0) begin : g_bad_osize
    $error("fifo_rd_unpack: DSIZE must be a multiple of OSIZE");
  end
  if (FRAME_LEN < 1) begin : g_bad_frame
    $error("fifo_rd_unpack: FRAME_LEN must be at least 1");
  end

  rd_state_t                    state_p0, state_d;
  logic [LANES-1:0][OSIZE-1:0]  hold_p0;
  logic [LANE_W-1:0]            lane_p0;
  logic [ELEM_W-1:0]            elem_p0;
  logic                         run_p0;
  logic                         fdone_p0;
  logic                         hold_valid;
  logic                         xfer;
  logic                         last_lane;
  logic                         last_elem;

  assign hold_valid = (state_p0 == ST_STREAM);
  assign xfer       = hold_valid & m_ready;
  assign last_lane  = (lane_p0 == LANE_W'(LANES - 1));
  assign last_elem  = (elem_p0 == ELEM_W'(FRAME_LEN - 1));

  // run_p0 keeps the pop quiet for the first cycle after reset release.
  assign rinc = rrst_n & run_p0 & ~rempty & (~hold_valid | (xfer & last_lane));

  assign m_valid    = hold_valid;
  assign m_data     = hold_valid ? hold_p0[lane_p0] : '0;
  assign m_last     = hold_valid & last_elem;
  assign frame_done = fdone_p0;

  always_comb begin
    state_d = state_p0;
    case (state_p0)
      ST_EMPTY:  if (rinc) state_d = ST_STREAM;
      ST_STREAM: if (xfer && last_lane && !rinc) state_d = ST_EMPTY;
      default:   state_d = ST_EMPTY;
    endcase
  end

  // ---- stage p0: control registers ----
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_p0 <= ST_EMPTY;
      lane_p0  <= '0;
      elem_p0  <= '0;
      run_p0   <= 1'b0;
      fdone_p0 <= 1'b0;
    end else begin
      state_p0 <= state_d;
      run_p0   <= 1'b1;
      fdone_p0 <= xfer & last_elem;
      if (rinc)
        lane_p0 <= '0;
      else if (xfer && !last_lane)
        lane_p0 <= lane_p0 + LANE_W'(1);
      if (xfer)
        elem_p0 <= last_elem ? '0 : elem_p0 + ELEM_W'(1);
    end
  end

  // ---- stage p0: held FIFO word ----
  always_ff @(posedge rclk) begin
    if (rinc)
      hold_p0 <= rdata;
  end

endmodule

// File: tb/tb_fifo_rd_unpack.sv
// Directed bench for fifo_rd_unpack with FRAME_LEN=12 and a queue-based FIFO model.
module tb_fifo_rd_unpack;
  localparam int DSIZE = 128;
  localparam int OSIZE = 16;
  localparam int FLEN  = 12;

  typedef struct {
    logic        rst_n;
    logic        ready;
    logic        v;
    logic [15:0] d;
    logic        l;
    logic        r;
    logic        f;
  } vec_t;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic [DSIZE-1:0] rdata;
  logic             rempty;
  logic             rinc;
  logic [OSIZE-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic             frame_done;

  logic [DSIZE-1:0] q[$];
  logic             rinc_s = 1'b0;
  vec_t             tbl[$];
  int               nvec = 0;
  int               nerr = 0;

  always #5 rclk = ~rclk;

  fifo_rd_unpack #(.DSIZE(DSIZE), .OSIZE(OSIZE), .FRAME_LEN(FLEN)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty), .rinc(rinc),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .frame_done(frame_done)
  );

  function automatic logic [DSIZE-1:0] mkword(input logic [15:0] base);
    logic [DSIZE-1:0] w;
    for (int l = 0; l < 8; l++) w[l*16 +: 16] = base + 16'(l);
    return w;
  endfunction

  // One cycle: retire the pop seen last cycle, drive inputs, sample before the edge.
  task automatic tick(input logic rst_n_i, input logic ready_i);
    @(negedge rclk);
    if (rinc_s && q.size() > 0) q.delete(0);
    rrst_n  = rst_n_i;
    m_ready = ready_i;
    rempty  = (q.size() == 0);
    rdata   = rempty ? '0 : q[0];
    #1;
    rinc_s  = rinc;
  endtask

  task automatic check(input string name, input logic v, input logic [15:0] d,
                       input logic l, input logic r, input logic f);
    nvec++;
    if ({m_valid, m_data, m_last, rinc, frame_done} !== {v, d, l, r, f}) begin
      nerr++;
      $display("FAIL %s: got v=%b d=%h last=%b rinc=%b fd=%b, want v=%b d=%h last=%b rinc=%b fd=%b",
               name, m_valid, m_data, m_last, rinc, frame_done, v, d, l, r, f);
    end
  endtask

  task automatic check_rinc(input string name, input logic r);
    nvec++;
    if (rinc !== r) begin
      nerr++;
      $display("FAIL %s: got rinc=%b, want rinc=%b", name, rinc, r);
    end
  endtask

  task automatic add(input logic rst_n_i, input logic ready_i, input logic v,
                     input logic [15:0] d, input logic l, input logic r, input logic f);
    vec_t e;
    e.rst_n = rst_n_i; e.ready = ready_i; e.v = v; e.d = d; e.l = l; e.r = r; e.f = f;
    tbl.push_back(e);
  endtask

  initial begin
    rrst_n = 1'b0; m_ready = 1'b1; rempty = 1'b1; rdata = '0;

    q.push_back(mkword(16'h0000));
    q.push_back(mkword(16'h0010));
    q.push_back(mkword(16'h0020));

    // Reset held with a non-empty FIFO, then release: one quiet cycle before the pop.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    // Word 0: lanes 0..7, reload of word 1 on the lane-7 transfer.
    for (int l = 0; l < 8; l++) add(1'b1, 1'b1, 1'b1, 16'(l), 1'b0, (l == 7), 1'b0);
    // Word 1: stall 5 cycles at lane 3, which is also element 11 (frame end).
    for (int l = 0; l < 3; l++) add(1'b1, 1'b1, 1'b1, 16'h0010 + 16'(l), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) add(1'b1, 1'b0, 1'b1, 16'h0013, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'h0013, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'h0014, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b1, 16'h0015, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'h0016, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'h0017, 1'b0, 1'b1, 1'b0);
    // Word 2: FIFO now empty, so no pop on lane 7; frame ends on lane 7.
    for (int l = 0; l < 7; l++) add(1'b1, 1'b1, 1'b1, 16'h0020 + 16'(l), 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 16'h0027, 1'b1, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    tick(1'b0, 1'b1);
    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].rst_n, tbl[i].ready);
      check($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].r, tbl[i].f);
    end

    // Reset at lane 5 of a word: word discarded, elem restarts from 0.
    q.push_back(mkword(16'h0030));
    q.push_back(mkword(16'h0040));
    q.push_back(mkword(16'h0050));
    tick(1'b1, 1'b1);
    check("rst_reload", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int l = 0; l < 5; l++) begin
      tick(1'b1, 1'b1);
      check($sformatf("rst_w3_lane%0d", l), 1'b1, 16'h0030 + 16'(l), 1'b0, 1'b0, 1'b0);
    end
    tick(1'b0, 1'b1);
    check_rinc("rst_assert_rinc", 1'b0);
    tick(1'b1, 1'b1);
    check("rst_release", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b1);
    check("rst_first_pop", 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < FLEN; i++) begin
      tick(1'b1, 1'b1);
      check($sformatf("rst_elem%0d", i), 1'b1,
            (i < 8) ? 16'h0040 + 16'(i) : 16'h0050 + 16'(i - 8),
            (i == FLEN - 1), (i == 7), 1'b0);
    end
    tick(1'b1, 1'b1);
    check("rst_frame_done", 1'b1, 16'h0054, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
